// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V core front end: data width,
// canonical NOP, fetch FSM states and the sequential PC step.
package riscv_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0
   localparam logic [31:0] PC_STEP   = 32'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register: reset load, redirect load (word-aligned) and
// sequential increment. The increment wraps naturally modulo 2^XLEN.
module pc_reg #(
   parameter int               XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic [XLEN-1:0] i_load_pc,
   input  logic            i_inc,
   output logic [XLEN-1:0] o_pc
);
   import riscv_pkg::*;

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_load_aligned;

   // Instructions are word aligned; the low address bits are dropped on load.
   assign w_load_aligned = {i_load_pc[XLEN-1:2], 2'b00};

   // PC update: a redirect load wins over the sequential step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_pc <= RESET_PC;
      else if (i_load) r_pc <= w_load_aligned;
      else if (i_inc)  r_pc <= r_pc + XLEN'(PC_STEP);
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one outstanding word read at a time to
// instruction memory and presents the fetched word to decode with its PC.
// Redirects from the branch unit take priority over every other event;
// responses for requests overtaken by a redirect are discarded.
// Optional build macro IF_MISALIGN_CHK_EN: a redirect to a non-word-aligned
// target raises a sticky fetch_err and parks the fetch unit in IDLE.
module instr_fetch #(
   parameter int               XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            id_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            fetch_err
);
   import riscv_pkg::*;

   fetch_state_e    r_state, w_state_nxt;
   logic            r_discard, w_discard_nxt;
   logic            r_instr_valid, w_valid_nxt;
   logic [XLEN-1:0] r_instr, r_instr_pc;
   logic            r_fetch_err, w_err_nxt;
   logic            w_latch;
   logic            w_pc_load, w_pc_inc;
   logic [XLEN-1:0] w_pc;
   logic            w_redir, w_redir_bad;

`ifdef IF_MISALIGN_CHK_EN
   assign w_redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
   assign w_redir_bad = 1'b0;
`endif
   assign w_redir = redirect_valid && !w_redir_bad;

   pc_reg #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_pc_load),
      .i_load_pc (redirect_pc),
      .i_inc     (w_pc_inc),
      .o_pc      (w_pc)
   );

   // Next-state decode; redirect is checked first in every state.
   always_comb begin
      w_state_nxt   = r_state;
      w_discard_nxt = r_discard;
      w_valid_nxt   = r_instr_valid;
      w_err_nxt     = r_fetch_err;
      w_latch       = 1'b0;
      w_pc_load     = 1'b0;
      w_pc_inc      = 1'b0;
      if (w_redir_bad) begin
         // Park: nothing outstanding is tracked, so any late rvalid is ignored.
         w_err_nxt     = 1'b1;
         w_state_nxt   = IDLE;
         w_discard_nxt = 1'b0;
         w_valid_nxt   = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               w_pc_load = w_redir;
               if (!r_fetch_err) w_state_nxt = REQ;
            end
            REQ: begin
               if (w_redir) begin
                  w_pc_load = 1'b1;
                  if (imem_gnt) begin
                     w_discard_nxt = 1'b1;
                     w_state_nxt   = WAIT;
                  end
               end else if (imem_gnt) begin
                  w_state_nxt = WAIT;
               end
            end
            WAIT: begin
               if (w_redir) begin
                  w_pc_load = 1'b1;
                  if (imem_rvalid) begin
                     // Response arrives with the redirect: drop it, refetch.
                     w_discard_nxt = 1'b0;
                     w_state_nxt   = REQ;
                  end else begin
                     w_discard_nxt = 1'b1;
                  end
               end else if (imem_rvalid) begin
                  if (r_discard) begin
                     w_discard_nxt = 1'b0;
                     w_state_nxt   = REQ;
                  end else begin
                     w_latch     = 1'b1;
                     w_valid_nxt = 1'b1;
                     w_state_nxt = HOLD;
                  end
               end
            end
            HOLD: begin
               if (w_redir) begin
                  // Not consumed: PC takes the target, no increment.
                  w_pc_load   = 1'b1;
                  w_valid_nxt = 1'b0;
                  w_state_nxt = REQ;
               end else if (id_ready) begin
                  w_pc_inc    = 1'b1;
                  w_valid_nxt = 1'b0;
                  w_state_nxt = REQ;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Control state: FSM, discard flag, valid and sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_discard     <= 1'b0;
         r_instr_valid <= 1'b0;
         r_fetch_err   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_discard     <= w_discard_nxt;
         r_instr_valid <= w_valid_nxt;
         r_fetch_err   <= w_err_nxt;
      end
   end

   // Instruction/PC capture on a right-path response; held stable in HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr    <= XLEN'(NOP_INSTR);
         r_instr_pc <= '0;
      end else if (w_latch) begin
         r_instr    <= imem_rdata;
         r_instr_pc <= w_pc;
      end
   end

   assign imem_req    = (r_state == REQ);
   assign imem_addr   = w_pc;
   assign instr_valid = r_instr_valid;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;

`ifdef IF_MISALIGN_CHK_EN
   assign fetch_err = r_fetch_err;
`else
   assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by a randomized run
// checked against a stream model (expected PC sequence + memory contents).
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        fetch_err;

   int n_vec = 0;
   int n_err = 0;

   instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_err      (fetch_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a ^ 32'hA5A5_5A5A) * 32'h0001_0003 + 32'h13;
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0;
      id_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
   endtask

   // Memory responder for one fetch: grant immediately, data next cycle.
   task automatic fetch_one(input logic [31:0] data, output logic [31:0] addr);
      int t = 0;
      while (!imem_req && t < 20) begin cyc(); t++; end
      n_vec++;
      if (imem_req !== 1'b1) begin
         n_err++;
         $display("FAIL fetch_req_timeout: imem_req=%b expected 1", imem_req);
      end
      addr = imem_addr;
      imem_gnt = 1'b1; cyc();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = data; cyc();
      imem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      cyc(); cyc();
      n_vec++;
      if ({imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err} !==
          {1'b0, 32'h0, 1'b0, 32'h0000_0013, 32'h0, 1'b0}) begin
         n_err++;
         $display("FAIL reset_state: req=%b addr=%h v=%b instr=%h pc=%h err=%b expected 0 0 0 00000013 0 0",
                  imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_err);
      end
      rst_n = 1'b1;
      cyc();
      n_vec++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         n_err++;
         $display("FAIL reset_first_req: req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
      end
   endtask

   task automatic test_basic_fetch();
      logic [31:0] a;
      fetch_one(32'h0070_0013, a);
      n_vec++;
      if (a !== 32'h0) begin
         n_err++; $display("FAIL basic_addr: got %h expected 00000000", a);
      end
      n_vec++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h0070_0013, 32'h0}) begin
         n_err++;
         $display("FAIL basic_present: v=%b instr=%h pc=%h expected 1 00700013 00000000",
                  instr_valid, instr, instr_pc);
      end
      id_ready = 1'b1; cyc(); id_ready = 1'b0;
      n_vec++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h4, 1'b0}) begin
         n_err++;
         $display("FAIL basic_next_addr: req=%b addr=%h v=%b expected 1 00000004 0",
                  imem_req, imem_addr, instr_valid);
      end
   endtask

   task automatic test_hold_stall();
      logic [31:0] a;
      fetch_one(32'h1234_5678, a);
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if ({instr_valid, instr, instr_pc, imem_req} !== {1'b1, 32'h1234_5678, 32'h4, 1'b0}) begin
            n_err++;
            $display("FAIL hold_stable[%0d]: v=%b instr=%h pc=%h req=%b expected 1 12345678 00000004 0",
                     i, instr_valid, instr, instr_pc, imem_req);
         end
         cyc();
      end
      id_ready = 1'b1; cyc(); id_ready = 1'b0;
      n_vec++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
         n_err++;
         $display("FAIL hold_release: req=%b addr=%h expected 1 00000008", imem_req, imem_addr);
      end
   endtask

   task automatic test_redirect_wait();
      logic [31:0] a;
      imem_gnt = 1'b1; cyc();
      imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100; cyc();
      redirect_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; cyc();
      imem_rvalid = 1'b0;
      n_vec++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0}) begin
         n_err++;
         $display("FAIL redir_wait_refetch: req=%b addr=%h v=%b expected 1 00000100 0",
                  imem_req, imem_addr, instr_valid);
      end
      fetch_one(32'h0000_0093, a);
      n_vec++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h0000_0093, 32'h100}) begin
         n_err++;
         $display("FAIL redir_wait_present: v=%b instr=%h pc=%h expected 1 00000093 00000100",
                  instr_valid, instr, instr_pc);
      end
      id_ready = 1'b1; cyc(); id_ready = 1'b0;
   endtask

   task automatic test_redirect_hold();
      logic [31:0] a;
      fetch_one(32'h0000_0113, a);
      n_vec++;
      if ({instr_valid, instr_pc} !== {1'b1, 32'h104}) begin
         n_err++;
         $display("FAIL redir_hold_setup: v=%b pc=%h expected 1 00000104", instr_valid, instr_pc);
      end
      id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; cyc();
      id_ready = 1'b0; redirect_valid = 1'b0;
      n_vec++;
      if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
         n_err++;
         $display("FAIL redir_hold: v=%b req=%b addr=%h expected 0 1 00000200",
                  instr_valid, imem_req, imem_addr);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] a;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; cyc();
      redirect_valid = 1'b0;
      n_vec++;
      if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
         n_err++;
         $display("FAIL wrap_redir_req: req=%b addr=%h expected 1 fffffffc", imem_req, imem_addr);
      end
      fetch_one(32'h0000_0193, a);
      n_vec++;
      if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h0000_0193, 32'hFFFF_FFFC}) begin
         n_err++;
         $display("FAIL wrap_present: v=%b instr=%h pc=%h expected 1 00000193 fffffffc",
                  instr_valid, instr, instr_pc);
      end
      id_ready = 1'b1; cyc(); id_ready = 1'b0;
      n_vec++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         n_err++;
         $display("FAIL wrap_next: req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
      end
   endtask

   task automatic test_misalign();
      redirect_valid = 1'b1; redirect_pc = 32'h102; cyc();
      redirect_valid = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if ({fetch_err, imem_req} !== 2'b10) begin
            n_err++;
            $display("FAIL misalign_park[%0d]: err=%b req=%b expected 1 0", i, fetch_err, imem_req);
         end
         cyc();
      end
`else
      n_vec++;
      if ({fetch_err, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
         n_err++;
         $display("FAIL misalign_mask: err=%b req=%b addr=%h expected 0 1 00000100",
                  fetch_err, imem_req, imem_addr);
      end
`endif
   endtask

   // Random handshakes, latencies and redirects. The model only tracks
   // which PC must be handed to decode next and what memory holds there.
   task automatic test_random();
      logic [31:0] exp_pc, pend_data, prev_addr;
      int          pend_cnt, n_hs;
      bit          pend, prev_hold;
      idle_inputs();
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      exp_pc = 32'h0; pend = 0; pend_cnt = 0; pend_data = 0;
      prev_hold = 0; prev_addr = 0; n_hs = 0;
      for (int c = 0; c < 600; c++) begin
         if (imem_req) begin
            n_vec++;
            if ({pend, imem_addr[1:0]} !== 3'b000) begin
               n_err++;
               $display("FAIL rand_req_proto c=%0d: outstanding=%b addr_lo=%b expected 0 00",
                        c, pend, imem_addr[1:0]);
            end
         end
         if (prev_hold && imem_req) begin
            n_vec++;
            if (imem_addr !== prev_addr) begin
               n_err++;
               $display("FAIL rand_addr_stable c=%0d: addr=%h expected %h", c, imem_addr, prev_addr);
            end
         end
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (pend) begin
            if (pend_cnt == 0) begin
               imem_rvalid = 1'b1; imem_rdata = pend_data; pend = 0;
            end else begin
               pend_cnt--;
            end
         end
         imem_gnt       = imem_req && ($urandom_range(0, 2) != 0);
         id_ready       = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 11) == 0);
         redirect_pc    = $urandom & 32'hFFFF_FFFC;
         if (instr_valid && id_ready && !redirect_valid) begin
            n_vec++; n_hs++;
            if ({instr_pc, instr} !== {exp_pc, memf(exp_pc)}) begin
               n_err++;
               $display("FAIL rand_stream c=%0d: pc=%h instr=%h expected %h %h",
                        c, instr_pc, instr, exp_pc, memf(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
         end
         if (redirect_valid) exp_pc = redirect_pc;
         if (imem_gnt) begin
            pend = 1; pend_cnt = $urandom_range(0, 2); pend_data = memf(imem_addr);
         end
         prev_hold = imem_req && !imem_gnt && !redirect_valid;
         prev_addr = imem_addr;
         cyc();
      end
      idle_inputs();
      n_vec++;
      if (n_hs < 20) begin
         n_err++;
         $display("FAIL rand_progress: handshakes=%0d expected at least 20", n_hs);
      end
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      test_reset();
      test_basic_fetch();
      test_hold_stall();
      test_redirect_wait();
      test_redirect_hold();
      test_wrap();
      test_misalign();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
